// File: rtl/baud_rate.sv
// rtl/baud_rate.sv - free-running modulo-M counter producing the UART oversampling tick
`timescale 1ns/1ps
module baud_rate #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int N          = 12,
  parameter int M          = (CLK_FREQ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE)
) (
  input  logic         clk,
  input  logic         rst,
  output logic         tick,
  output logic [N-1:0] q
);

  if (M < 2 || longint'(M) > (longint'(1) << N)) begin : g_bad_m
    $fatal(1, "baud_rate: M must satisfy 2 <= M <= 2**N");
  end

  localparam logic [N-1:0] LAST = N'(M - 1);
  localparam logic [N-1:0] ONE  = N'(1);

  // >= rather than == so an upset count beyond LAST still wraps on the next edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (q >= LAST) begin
      q <= '0;
    end else begin
      q <= q + ONE;
    end
  end

  assign tick = (q == LAST);

endmodule

// File: tb/tb_baud_rate.sv
// tb/tb_baud_rate.sv - scoreboard bench for baud_rate (default M=326 and M=4/N=3 instances)
`timescale 1ns/1ps
module tb_baud_rate;

  logic        clk = 1'b1;
  logic        rst = 1'b1;
  logic        tick;
  logic [11:0] q;
  logic        tick4;
  logic [2:0]  q4;

  int checks = 0;
  int failures = 0;
  longint exp_tick_q[$];   // expected tick rise times in ns
  int tick_count = 0;
  int max_q = 0;
  logic prev_tick = 1'b0;

  always #10 clk = ~clk;

  baud_rate dut (.clk(clk), .rst(rst), .tick(tick), .q(q));
  baud_rate #(.N(3), .M(4)) dut4 (.clk(clk), .rst(rst), .tick(tick4), .q(q4));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_until(input longint t);
    if (t > $time) #(t - $time);
  endtask

  // monitor: every observed tick pops one expected rise time
  always @(negedge clk) begin
    longint t;
    if (int'(q) > max_q) max_q = int'(q);
    if (tick === 1'b1) begin
      tick_count++;
      if (exp_tick_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_tick actual=tick at %0t required=no tick", $time);
      end else begin
        t = exp_tick_q.pop_front();
        check("tick_time", 64'($time - 10), 64'(t));
        check("tick_q", 64'(q), 64'd325);
      end
      if (prev_tick === 1'b1) check("tick_width", 64'(prev_tick & tick), 64'd0);
    end
    prev_tick = tick;
  end

  logic [2:0] exp_q4 [8] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
  logic       exp_t4 [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    longint te;
    bit found;
    for (int k = 0; k < 153; k++) exp_tick_q.push_back(longint'(6500 + 6520 * k));

    #1;
    check("reset_q", 64'(q), 64'd0);
    check("reset_tick", 64'(tick), 64'd0);
    check("reset_q4", 64'(q4), 64'd0);
    check("reset_tick4", 64'(tick4), 64'd0);
    wait_until(10);
    rst = 1'b0;

    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      check("q_first_edges", 64'(q), 64'(k + 1));
      check("m4_q", 64'(q4), 64'(exp_q4[k]));
      check("m4_tick", 64'(tick4), 64'(exp_t4[k]));
    end

    wait_until(2001);
    check("q_edge100", 64'(q), 64'd100);
    wait_until(6481);
    check("q_edge324", 64'(q), 64'd324);
    check("tick_edge324", 64'(tick), 64'd0);
    wait_until(6501);
    check("q_first_tick", 64'(q), 64'd325);
    check("first_tick", 64'(tick), 64'd1);
    wait_until(6521);
    check("q_wrap", 64'(q), 64'd0);
    check("tick_after_wrap", 64'(tick), 64'd0);

    wait_until(1_000_010);
    check("ticks_in_1ms", 64'(tick_count), 64'd153);
    check("tick_queue_drained", 64'(exp_tick_q.size()), 64'd0);
    check("max_q_le_325", 64'(max_q <= 325), 64'd1);

    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (q == 12'd200) found = 1'b1;
    end
    check("found_q200", 64'(found), 64'd1);

    #3;
    rst = 1'b1;
    #1;
    check("async_rst_q", 64'(q), 64'd0);
    check("async_rst_tick", 64'(tick), 64'd0);
    @(posedge clk);
    #1;
    check("held_rst_q", 64'(q), 64'd0);
    check("held_rst_q4", 64'(q4), 64'd0);
    #5;
    rst = 1'b0;
    @(posedge clk);
    te = $time;
    exp_tick_q.push_back(te + 324 * 20);
    #1;
    check("q_after_rerelease", 64'(q), 64'd1);

    for (int i = 0; i < 330; i++) @(posedge clk);
    #1;
    check("ticks_after_rerelease", 64'(tick_count), 64'd154);
    check("tick_queue_final", 64'(exp_tick_q.size()), 64'd0);
    check("q_after_330", 64'(q), 64'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
